cpu_run_ctrl: RTL

//  Run sequencer for the cpu_acc accumulator CPU. On start: streams a program image into instruction memory,

---
 rtl/cpu_acc_pkg.sv | 15 +
 rtl/run_watchdog.sv | 23 ++
 rtl/cpu_run_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_acc_pkg.sv
// Shared types and default widths for the cpu_acc run sequencer.
package cpu_acc_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CPU_RST,
        RUN,
        DONE
    } run_state_t;

endpackage

// File: rtl/run_watchdog.sv
// Up-counter with synchronous clear and enable; flags when the count reaches a runtime limit.
module run_watchdog #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == last);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for cpu_acc: load program image, hold CPU in reset, run under a watchdog,
// then latch result, cycle count and pass/fail.
module cpu_run_ctrl
    import cpu_acc_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] exp_val,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halted,
    input  logic [DATA_W-1:0] cpu_acc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              load_err,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  cycles
);

    run_state_t        state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] exp_q, exp_n;
    logic [DATA_W-1:0] result_q, result_n;
    logic [CNT_W-1:0]  cycles_q, cycles_n;
    logic              pass_q, pass_n;
    logic              timeout_q, timeout_n;
    logic              load_err_q, load_err_n;
    logic              cpu_reset_q, cpu_reset_n;

    logic              wd_clear;
    logic              wd_enable;
    logic [CNT_W-1:0]  wd_last;
    logic [CNT_W-1:0]  wd_count;
    logic              wd_expired;

    // One counter serves both the reset hold and the run watchdog; it is cleared
    // on the hold->run transition so RUN starts counting from zero.
    assign wd_enable = (state == CPU_RST) || (state == RUN);
    assign wd_last   = (state == CPU_RST) ? CNT_W'(RST_CYCLES - 1) : CNT_W'(TIMEOUT - 1);
    assign wd_clear  = !reset || !wd_enable || ((state == CPU_RST) && wd_expired);

    run_watchdog #(
        .CNT_W(CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .clear  (wd_clear),
        .enable (wd_enable),
        .last   (wd_last),
        .count  (wd_count),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            addr        <= '0;
            exp_q       <= '0;
            result_q    <= '0;
            cycles_q    <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            load_err_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            exp_q       <= exp_n;
            result_q    <= result_n;
            cycles_q    <= cycles_n;
            pass_q      <= pass_n;
            timeout_q   <= timeout_n;
            load_err_q  <= load_err_n;
            cpu_reset_q <= cpu_reset_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        exp_n       = exp_q;
        result_n    = result_q;
        cycles_n    = cycles_q;
        pass_n      = pass_q;
        timeout_n   = timeout_q;
        load_err_n  = load_err_q;
        cpu_reset_n = cpu_reset_q;
        ld_ready    = 1'b0;
        imem_we     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = LOAD;
                    exp_n       = exp_val;
                    addr_n      = '0;
                    result_n    = '0;
                    cycles_n    = '0;
                    pass_n      = 1'b0;
                    timeout_n   = 1'b0;
                    load_err_n  = 1'b0;
                    cpu_reset_n = 1'b1;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    imem_we = 1'b1;
                    if (addr != '1) begin
                        addr_n = addr + ADDR_W'(1);
                    end
                    if (ld_last) begin
                        state_n = CPU_RST;
                    end else if (addr == '1) begin
                        load_err_n = 1'b1;
                        state_n    = DONE;
                    end
                end
            end
            CPU_RST: begin
                if (wd_expired) begin
                    state_n     = RUN;
                    cpu_reset_n = 1'b0;
                end
            end
            RUN: begin
                // Halt takes priority over a same-cycle watchdog expiry.
                if (cpu_halted) begin
                    result_n = cpu_acc;
                    cycles_n = wd_count;
                    pass_n   = (cpu_acc == exp_q);
                    state_n  = DONE;
                end else if (wd_expired) begin
                    timeout_n   = 1'b1;
                    result_n    = cpu_acc;
                    cycles_n    = CNT_W'(TIMEOUT);
                    cpu_reset_n = 1'b1;
                    state_n     = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign imem_addr  = addr;
    assign imem_wdata = ld_data;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = (state == LOAD) || (state == CPU_RST) || (state == RUN);
    assign done       = (state == DONE);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign load_err   = load_err_q;
    assign result     = result_q;
    assign cycles     = cycles_q;

endmodule
